// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencing state encoding and register-file constants.
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    ST_RUN              = 1'b0,
    ST_REDIRECT_PENDING = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A load in EX feeds a source the ID instruction actually reads; x0 never hazards.
  function automatic logic load_use_hazard(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] rs1,
    input logic       uses_rs1,
    input logic [4:0] rs2,
    input logic       uses_rs2
  );
    return ex_mem_read && (ex_rd != REG_ZERO) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  output logic [WIDTH-1:0] COUNT
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                   COUNT <= '0;
    else if (EN && (COUNT != '1)) COUNT <= COUNT + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline sequencer: per-cycle hold/flush of the pipeline registers
// and PC select, covering memory freezes, load-use bubbles and branch redirects.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     IMEM_BUSYWAIT,
  input  logic                     DMEM_BUSYWAIT,
  input  logic [4:0]               ID_RS1_ADDR,
  input  logic [4:0]               ID_RS2_ADDR,
  input  logic                     ID_USES_RS1,
  input  logic                     ID_USES_RS2,
  input  logic [4:0]               EX_RD_ADDR,
  input  logic                     EX_MEM_READ,
  input  logic                     EX_BRANCH_TAKEN,
  input  logic [31:0]              EX_BRANCH_TARGET,
  output logic                     PC_HOLD,
  output logic                     PC_REDIRECT,
  output logic [31:0]              REDIRECT_ADDR,
  output logic                     IF_ID_HOLD,
  output logic                     ID_EX_HOLD,
  output logic                     EX_MEM_HOLD,
  output logic                     MEM_WB_HOLD,
  output logic                     IF_ID_FLUSH,
  output logic                     ID_EX_FLUSH,
  output logic [COUNTER_WIDTH-1:0] STALL_COUNT,
  output logic [COUNTER_WIDTH-1:0] FLUSH_COUNT
);

  hz_state_e   state, state_nxt;
  logic [31:0] target_q;
  logic        latch_target;
  logic        hazard;

  assign hazard = load_use_hazard(EX_MEM_READ, EX_RD_ADDR, ID_RS1_ADDR, ID_USES_RS1,
                                  ID_RS2_ADDR, ID_USES_RS2);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_RUN;
      target_q <= '0;
    end else begin
      state <= state_nxt;
      if (latch_target) target_q <= EX_BRANCH_TARGET;
    end
  end

  always_comb begin
    state_nxt     = state;
    latch_target  = 1'b0;
    PC_HOLD       = 1'b0;
    PC_REDIRECT   = 1'b0;
    REDIRECT_ADDR = EX_BRANCH_TARGET;
    IF_ID_HOLD    = 1'b0;
    ID_EX_HOLD    = 1'b0;
    EX_MEM_HOLD   = 1'b0;
    MEM_WB_HOLD   = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    if (RESET) begin
      REDIRECT_ADDR = '0;
    end else if (DMEM_BUSYWAIT) begin
      // Global freeze: EX is re-presented afterwards, so its branch is ignored now.
      PC_HOLD     = 1'b1;
      IF_ID_HOLD  = 1'b1;
      ID_EX_HOLD  = 1'b1;
      EX_MEM_HOLD = 1'b1;
      MEM_WB_HOLD = 1'b1;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
            if (IMEM_BUSYWAIT) begin
              // Fetch in flight: park the target until the fetch returns.
              PC_HOLD      = 1'b1;
              latch_target = 1'b1;
              state_nxt    = ST_REDIRECT_PENDING;
            end else begin
              PC_REDIRECT = 1'b1;
            end
          end else if (hazard || IMEM_BUSYWAIT) begin
            PC_HOLD     = 1'b1;
            IF_ID_HOLD  = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end
        end
        ST_REDIRECT_PENDING: begin
          REDIRECT_ADDR = target_q;
          IF_ID_FLUSH   = 1'b1;
          ID_EX_FLUSH   = 1'b1;
          if (IMEM_BUSYWAIT) begin
            PC_HOLD = 1'b1;
          end else begin
            PC_REDIRECT = 1'b1;
            state_nxt   = ST_RUN;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (PC_HOLD),
    .COUNT (STALL_COUNT)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (IF_ID_FLUSH),
    .COUNT (FLUSH_COUNT)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with a 4-bit counter build.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_pipeline_hazard_controller;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          IMEM_BUSYWAIT, DMEM_BUSYWAIT;
  logic [4:0]    ID_RS1_ADDR, ID_RS2_ADDR, EX_RD_ADDR;
  logic          ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_BRANCH_TAKEN;
  logic [31:0]   EX_BRANCH_TARGET;
  logic          PC_HOLD, PC_REDIRECT;
  logic [31:0]   REDIRECT_ADDR;
  logic          IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD;
  logic          IF_ID_FLUSH, ID_EX_FLUSH;
  logic [CW-1:0] STALL_COUNT, FLUSH_COUNT;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_controller #(.COUNTER_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
    .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
    .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
    .EX_RD_ADDR(EX_RD_ADDR), .EX_MEM_READ(EX_MEM_READ),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN), .EX_BRANCH_TARGET(EX_BRANCH_TARGET),
    .PC_HOLD(PC_HOLD), .PC_REDIRECT(PC_REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
    .IF_ID_HOLD(IF_ID_HOLD), .ID_EX_HOLD(ID_EX_HOLD),
    .EX_MEM_HOLD(EX_MEM_HOLD), .MEM_WB_HOLD(MEM_WB_HOLD),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
    .STALL_COUNT(STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
  );

  // Packed control view: {PC_HOLD,PC_REDIRECT,IF_ID_HOLD,ID_EX_HOLD,EX_MEM_HOLD,MEM_WB_HOLD,IF_ID_FLUSH,ID_EX_FLUSH}
  logic [7:0] ctl;
  assign ctl = {PC_HOLD, PC_REDIRECT, IF_ID_HOLD, ID_EX_HOLD,
                EX_MEM_HOLD, MEM_WB_HOLD, IF_ID_FLUSH, ID_EX_FLUSH};

  localparam logic [7:0] C_IDLE     = 8'b0000_0000;
  localparam logic [7:0] C_STALL    = 8'b1010_0001;  // PC_HOLD, IF_ID_HOLD, ID_EX_FLUSH
  localparam logic [7:0] C_REDIR    = 8'b0100_0011;  // PC_REDIRECT, both flushes
  localparam logic [7:0] C_PEND     = 8'b1000_0011;  // PC_HOLD, both flushes
  localparam logic [7:0] C_FREEZE   = 8'b1011_1100;  // PC_HOLD and all register holds

  task automatic idle_inputs();
    IMEM_BUSYWAIT = 0; DMEM_BUSYWAIT = 0;
    ID_RS1_ADDR = 0; ID_RS2_ADDR = 0; ID_USES_RS1 = 0; ID_USES_RS2 = 0;
    EX_RD_ADDR = 0; EX_MEM_READ = 0; EX_BRANCH_TAKEN = 0; EX_BRANCH_TARGET = 32'h0000_0500;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1; idle_inputs();
    next_cycle(); next_cycle();
    RESET = 0;
    IMEM_BUSYWAIT = 1;
    next_cycle(); next_cycle(); next_cycle();
    checks++;
    if (STALL_COUNT !== 4'd3) begin
      errors++; $display("FAIL reset_precount: STALL_COUNT=%0d expected 3", STALL_COUNT);
    end
    RESET = 1; #1;
    checks++;
    if (ctl !== C_IDLE || REDIRECT_ADDR !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: ctl=%b addr=%h expected %b addr 0", ctl, REDIRECT_ADDR, C_IDLE);
    end
    checks++;
    if (STALL_COUNT !== 4'd0 || FLUSH_COUNT !== 4'd0) begin
      errors++; $display("FAIL reset_counters: stall=%0d flush=%0d expected 0/0", STALL_COUNT, FLUSH_COUNT);
    end
    next_cycle();
    RESET = 0; IMEM_BUSYWAIT = 0;
    @(negedge CLK);
    checks++;
    if (ctl !== C_IDLE || REDIRECT_ADDR !== 32'h500) begin
      errors++; $display("FAIL reset_run_idle: ctl=%b addr=%h expected %b addr 500", ctl, REDIRECT_ADDR, C_IDLE);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    EX_MEM_READ = 1; EX_RD_ADDR = 5'd5; ID_RS2_ADDR = 5'd5; ID_USES_RS2 = 1;
    ID_RS1_ADDR = 5'd7; ID_USES_RS1 = 1;
    @(negedge CLK);
    checks++;
    if (ctl !== C_STALL) begin
      errors++; $display("FAIL load_use_bubble: ctl=%b expected %b", ctl, C_STALL);
    end
    next_cycle();
    EX_MEM_READ = 0;  // load has moved to MEM
    @(negedge CLK);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL load_use_clear: ctl=%b expected %b", ctl, C_IDLE);
    end
    next_cycle();
    EX_MEM_READ = 1; EX_RD_ADDR = 5'd0; ID_RS1_ADDR = 5'd0; ID_RS2_ADDR = 5'd0;
    @(negedge CLK);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL load_use_x0: ctl=%b expected %b", ctl, C_IDLE);
    end
    next_cycle();
    EX_RD_ADDR = 5'd9; ID_RS1_ADDR = 5'd9; ID_USES_RS1 = 0; ID_RS2_ADDR = 5'd3;
    @(negedge CLK);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL load_use_unused_src: ctl=%b expected %b", ctl, C_IDLE);
    end
    next_cycle();
    idle_inputs();
    checks++;
    if (STALL_COUNT !== 4'd1 || FLUSH_COUNT !== 4'd0) begin
      errors++; $display("FAIL load_use_counts: stall=%0d flush=%0d expected 1/0", STALL_COUNT, FLUSH_COUNT);
    end
  endtask

  task automatic test_branch_idle();
    EX_BRANCH_TAKEN = 1; EX_BRANCH_TARGET = 32'h40;
    @(negedge CLK);
    checks++;
    if (ctl !== C_REDIR || REDIRECT_ADDR !== 32'h40) begin
      errors++; $display("FAIL branch_idle: ctl=%b addr=%h expected %b addr 40", ctl, REDIRECT_ADDR, C_REDIR);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_branch_pending();
    EX_BRANCH_TAKEN = 1; EX_BRANCH_TARGET = 32'h80; IMEM_BUSYWAIT = 1;
    @(negedge CLK);
    checks++;
    if (ctl !== C_PEND) begin
      errors++; $display("FAIL pend_enter: ctl=%b expected %b", ctl, C_PEND);
    end
    next_cycle();
    EX_BRANCH_TAKEN = 1; EX_BRANCH_TARGET = 32'h1234;  // ignored: EX holds a bubble
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (ctl !== C_PEND) begin
        errors++; $display("FAIL pend_wait%0d: ctl=%b expected %b", i, ctl, C_PEND);
      end
      next_cycle();
    end
    IMEM_BUSYWAIT = 0; EX_BRANCH_TAKEN = 0;
    @(negedge CLK);
    checks++;
    if (ctl !== C_REDIR || REDIRECT_ADDR !== 32'h80) begin
      errors++; $display("FAIL pend_issue: ctl=%b addr=%h expected %b addr 80", ctl, REDIRECT_ADDR, C_REDIR);
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (ctl !== C_IDLE || REDIRECT_ADDR !== 32'h1234) begin
      errors++; $display("FAIL pend_back_run: ctl=%b addr=%h expected %b addr 1234", ctl, REDIRECT_ADDR, C_IDLE);
    end
    checks++;
    if (STALL_COUNT !== 4'd4 || FLUSH_COUNT !== 4'd5) begin
      errors++; $display("FAIL pend_counts: stall=%0d flush=%0d expected 4/5", STALL_COUNT, FLUSH_COUNT);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_dmem_freeze_pending();
    EX_BRANCH_TAKEN = 1; EX_BRANCH_TARGET = 32'h80; IMEM_BUSYWAIT = 1;
    next_cycle();
    DMEM_BUSYWAIT = 1; EX_BRANCH_TARGET = 32'h99;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++; $display("FAIL freeze%0d: ctl=%b expected %b", i, ctl, C_FREEZE);
      end
      next_cycle();
    end
    DMEM_BUSYWAIT = 0; IMEM_BUSYWAIT = 0; EX_BRANCH_TAKEN = 0;
    @(negedge CLK);
    checks++;
    if (ctl !== C_REDIR || REDIRECT_ADDR !== 32'h80) begin
      errors++; $display("FAIL freeze_resume: ctl=%b addr=%h expected %b addr 80", ctl, REDIRECT_ADDR, C_REDIR);
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (ctl !== C_IDLE) begin
      errors++; $display("FAIL freeze_back_run: ctl=%b expected %b", ctl, C_IDLE);
    end
    checks++;
    if (STALL_COUNT !== 4'd7 || FLUSH_COUNT !== 4'd7) begin
      errors++; $display("FAIL freeze_counts: stall=%0d flush=%0d expected 7/7", STALL_COUNT, FLUSH_COUNT);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_reset_mid_pending();
    EX_BRANCH_TAKEN = 1; EX_BRANCH_TARGET = 32'hC0; IMEM_BUSYWAIT = 1;
    next_cycle();
    EX_BRANCH_TAKEN = 0;
    RESET = 1; #1;
    checks++;
    if (ctl !== C_IDLE || REDIRECT_ADDR !== 32'h0 || STALL_COUNT !== 4'd0) begin
      errors++; $display("FAIL reset_pend: ctl=%b addr=%h stall=%0d expected %b addr 0 stall 0",
                         ctl, REDIRECT_ADDR, STALL_COUNT, C_IDLE);
    end
    next_cycle();
    RESET = 0; IMEM_BUSYWAIT = 0;
    @(negedge CLK);
    checks++;
    if (ctl !== C_IDLE || REDIRECT_ADDR !== 32'h0C0) begin
      errors++; $display("FAIL reset_pend_discard: ctl=%b addr=%h expected %b addr c0", ctl, REDIRECT_ADDR, C_IDLE);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_saturation();
    IMEM_BUSYWAIT = 1;
    @(negedge CLK);
    checks++;
    if (ctl !== C_STALL) begin
      errors++; $display("FAIL imem_stall: ctl=%b expected %b", ctl, C_STALL);
    end
    for (int i = 0; i < 20; i++) next_cycle();
    checks++;
    if (STALL_COUNT !== 4'd15 || FLUSH_COUNT !== 4'd0) begin
      errors++; $display("FAIL saturate: stall=%0d flush=%0d expected 15/0", STALL_COUNT, FLUSH_COUNT);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_idle();
    test_branch_pending();
    test_dmem_freeze_pending();
    test_reset_mid_pending();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
